// File: rtl/pe_skew_feeder_if.sv
// pe_skew_feeder_if: tile load handshake and skewed activation feed to the PE array
interface pe_skew_feeder_if #(
  parameter int ROWS = 4,
  parameter int DW = 8,
  parameter int MAX_K = 16,
  localparam int KW = $clog2(MAX_K + 1)
);
  logic start;
  logic [KW-1:0] k_len;
  logic in_valid;
  logic in_ready;
  logic [ROWS-1:0][DW-1:0] in_a;
  logic [ROWS-1:0][DW-1:0] out_a;
  logic out_fire;
  logic busy;
  logic done;
  modport master (
    output start, k_len, in_valid, in_a,
    input in_ready, out_a, out_fire, busy, done
  );
  modport slave (
    input start, k_len, in_valid, in_a,
    output in_ready, out_a, out_fire, busy, done
  );
endinterface

// File: rtl/pe_skew_feeder.sv
// pe_skew_feeder: buffers one activation tile and streams it diagonally skewed into the PE array
module pe_skew_feeder #(
  parameter int ROWS = 4,
  parameter int DW = 8,
  parameter int MAX_K = 16,
  parameter int DRAIN_CYC = 4,
  localparam int KW = $clog2(MAX_K + 1)
) (
  input logic clk,
  input logic rstn,
  pe_skew_feeder_if.slave f
);
  localparam int SW = $clog2(MAX_K + ROWS);
  localparam int AW = MAX_K > 1 ? $clog2(MAX_K) : 1;
  localparam int DCW = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;
  typedef logic [ROWS-1:0][DW-1:0] vec_t;
  state_t state, state_n;
  logic [KW-1:0] klen, klen_n, wcnt, wcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [DCW-1:0] dcnt, dcnt_n;
  vec_t mem [MAX_K];
  vec_t a_n;
  logic acc;
  assign acc = state == LOAD && f.in_valid && f.in_ready;
  // next state and counters; outputs are registered from these lookahead values
  always_comb begin
    state_n = state;
    klen_n = klen;
    wcnt_n = acc ? wcnt + 1'b1 : wcnt;
    scnt_n = scnt;
    dcnt_n = dcnt;
    case (state)
      IDLE: if (f.start && f.k_len != '0) begin
        state_n = LOAD;
        klen_n = f.k_len > KW'(MAX_K) ? KW'(MAX_K) : f.k_len;
        wcnt_n = '0;
      end
      LOAD: if (acc && wcnt_n == klen) begin
        state_n = STREAM;
        scnt_n = '0;
      end
      STREAM: if (scnt == SW'(klen) + SW'(ROWS - 2)) begin
        state_n = DRAIN;
        dcnt_n = '0;
      end else scnt_n = scnt + 1'b1;
      DRAIN: if (dcnt == DCW'(DRAIN_CYC - 1)) state_n = IDLE;
        else dcnt_n = dcnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // skewed lane selection for the next stream cycle; the beat being written this edge is bypassed
  always_comb begin
    a_n = '0;
    for (int r = 0; r < ROWS; r++)
      a_n[r] = (int'(scnt_n) >= r && int'(scnt_n) - r < int'(klen)) ?
        ((acc && AW'(int'(scnt_n) - r) == wcnt[AW-1:0]) ? f.in_a[r] : mem[AW'(int'(scnt_n) - r)][r]) : '0;
  end
  // tile buffer, contents only meaningful below wcnt
  always_ff @(posedge clk) begin
    if (acc) mem[wcnt[AW-1:0]] <= f.in_a;
  end
  // state and counter registers
  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
      klen <= '0;
      wcnt <= '0;
      scnt <= '0;
      dcnt <= '0;
    end else begin
      state <= state_n;
      klen <= klen_n;
      wcnt <= wcnt_n;
      scnt <= scnt_n;
      dcnt <= dcnt_n;
    end
  end
  // registered outputs, zeroed outside their active states so no X reaches the array
  always_ff @(posedge clk) begin
    if (rstn) begin
      f.in_ready <= 1'b0;
      f.out_fire <= 1'b0;
      f.out_a <= '0;
      f.busy <= 1'b0;
      f.done <= 1'b0;
    end else begin
      f.in_ready <= state_n == LOAD;
      f.out_fire <= state_n == STREAM;
      f.out_a <= state_n == STREAM ? a_n : '0;
      f.busy <= state_n != IDLE;
      f.done <= state_n == DRAIN && dcnt_n == DCW'(DRAIN_CYC - 1);
    end
  end
endmodule

// File: tb/tb_pe_skew_feeder.sv
// tb_pe_skew_feeder: directed and randomized tiles checked against a skew reference model
module tb_pe_skew_feeder;
  localparam int ROWS = 4;
  localparam int DW = 8;
  localparam int MAX_K = 16;
  localparam int DRAIN_CYC = 4;
  localparam int KW = $clog2(MAX_K + 1);
  typedef logic [ROWS-1:0][DW-1:0] vec_t;
  logic clk, rstn;
  int checks = 0;
  int errors = 0;
  bit use_fixed = 0;
  vec_t vec [MAX_K];
  pe_skew_feeder_if #(.ROWS(ROWS), .DW(DW), .MAX_K(MAX_K)) f ();
  pe_skew_feeder #(.ROWS(ROWS), .DW(DW), .MAX_K(MAX_K), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rstn(rstn), .f(f)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic vec_t exp_a(input int s, input int kk);
    vec_t e = '0;
    for (int r = 0; r < ROWS; r++)
      if (s - r >= 0 && s - r < kk) e[r] = vec[s - r][r];
    return e;
  endfunction
  task automatic chk_idle(input string tag);
    chk({tag, "_fire"}, f.out_fire, 0);
    chk({tag, "_a"}, f.out_a, 0);
    chk({tag, "_busy"}, f.busy, 0);
    chk({tag, "_ready"}, f.in_ready, 0);
    chk({tag, "_done"}, f.done, 0);
  endtask
  // mode: 0 no stalls, 1 alternating valid, 2 random valid; poke pulses start in LOAD and DRAIN
  task automatic run_tile(input int kreq, input int mode, input bit poke, input int rst_at);
    int kk, acc, budget;
    bit tgl, vld;
    kk = kreq > MAX_K ? MAX_K : kreq;
    if (!use_fixed) for (int i = 0; i < MAX_K; i++) vec[i] = vec_t'($urandom);
    f.start = 1;
    f.k_len = KW'(kreq);
    step;
    f.start = 0;
    f.k_len = KW'($urandom_range(0, 20));
    chk("busy_load", f.busy, 1);
    acc = 0;
    budget = 0;
    tgl = 1;
    while (acc < kk && budget < 200) begin
      chk("ready_load", f.in_ready, 1);
      chk("fire_load", f.out_fire, 0);
      chk("a_load", f.out_a, 0);
      vld = mode == 0 || (mode == 1 ? tgl : $urandom_range(0, 1) == 1);
      tgl = !tgl;
      f.in_valid = vld;
      f.in_a = vld ? vec[acc] : vec_t'($urandom);
      if (poke && acc == 1) f.start = 1;
      step;
      f.start = 0;
      if (vld) acc++;
      budget++;
    end
    if (acc != kk) begin
      chk("load_timeout", acc, kk);
      return;
    end
    for (int s = 0; s < kk + ROWS - 1; s++) begin
      f.in_valid = $urandom_range(0, 1) == 1;
      f.in_a = vec_t'($urandom);
      chk("fire_stream", f.out_fire, 1);
      chk($sformatf("a_s%0d", s), f.out_a, exp_a(s, kk));
      chk("ready_stream", f.in_ready, 0);
      chk("busy_stream", f.busy, 1);
      chk("done_stream", f.done, 0);
      if (s == rst_at) begin
        rstn = 1;
        step;
        rstn = 0;
        f.in_valid = 0;
        chk_idle("after_rst");
        step;
        chk_idle("after_rst2");
        return;
      end
      step;
    end
    f.in_valid = 0;
    for (int d = 0; d < DRAIN_CYC; d++) begin
      chk("fire_drain", f.out_fire, 0);
      chk("a_drain", f.out_a, 0);
      chk("busy_drain", f.busy, 1);
      chk("done_drain", f.done, d == DRAIN_CYC - 1);
      if (poke && d == 1) begin
        f.start = 1;
        f.k_len = 3;
      end
      step;
      f.start = 0;
    end
    chk_idle("post_done");
  endtask
  initial begin
    rstn = 1;
    f.start = 0;
    f.k_len = '0;
    f.in_valid = 0;
    f.in_a = '0;
    repeat (3) step;
    chk_idle("reset");
    rstn = 0;
    step;
    f.start = 1;
    f.k_len = 0;
    step;
    f.start = 0;
    for (int i = 0; i < 3; i++) chk_idle("k0_ignored");
    use_fixed = 1;
    vec[0] = {8'h04, 8'h03, 8'h02, 8'h01};
    vec[1] = {8'h14, 8'h13, 8'h12, 8'h11};
    run_tile(2, 0, 0, -1);
    use_fixed = 0;
    step;
    run_tile(4, 1, 1, -1);
    step;
    run_tile(20, 0, 0, -1);
    step;
    run_tile(3, 0, 0, 2);
    run_tile(2, 0, 0, -1);
    run_tile(5, 0, 0, -1);
    run_tile(3, 2, 0, -1);
    run_tile(1, 0, 0, -1);
    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(0, 2)) step;
      run_tile($urandom_range(1, MAX_K), 2, t[0], -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_skew_feeder.md
Name: pe_skew_feeder

Overview:
Upstream feeder for the 4x4 PE array. It buffers one tile of activation vectors, each holding ROWS lanes of DW bits, accepted through a valid/ready handshake. It then streams the tile into the array's activation inputs with diagonal skew: lane r is delayed r cycles. It also generates the fire strobe for column 0, and waits out the array pipeline before signalling done.

Parameters:
ROWS, 4, number of activation lanes (array rows)
DW, 8, activation width in bits
MAX_K, 16, maximum vectors per tile (buffer depth)
DRAIN_CYC, 4, idle cycles after streaming for the array to flush (array column count)
KW, $clog2(MAX_K+1), width of k_len (derived; do not override)

Ports:
clk  input  1  clock; all logic on rising edge
rstn  input  1  synchronous active-high reset
start  input  1  begin a tile; sampled only in IDLE
k_len  input  KW  vectors in this tile; sampled with start
in_valid  input  1  upstream vector valid
in_ready  output  1  feeder can accept a vector
in_a  input  ROWS x DW  activation vector, lane r at index r
out_a  output  ROWS x DW  skewed activations to array in_a, registered
out_fire  output  1  fire strobe to array column 0, registered
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at end of tile

Behaviour:
- States: IDLE, LOAD, STREAM, DRAIN. All outputs are registered.
- Reset (rstn=1 at an edge) takes effect regardless of state, including mid-tile:
  - state goes to IDLE; counters clear
  - in_ready=0, out_a all 0, out_fire=0, busy=0, done=0
  - buffer contents are don't-care
- IDLE -> LOAD: on start=1 with k_len!=0.
  - k_len is latched, saturated to MAX_K if larger.
  - start with k_len=0 is ignored: stay in IDLE, no done.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1 from the first LOAD cycle.
  - A beat transfers when in_valid && in_ready; it is written to buf[wcnt], then wcnt increments.
  - When the transfer makes wcnt==k_len: in_ready drops next cycle, and the state goes to STREAM next cycle.
  - No bubbles required. in_valid gaps simply stall LOAD, with no timeout.
- STREAM: lasts exactly k_len+ROWS-1 cycles, indexed s=0..k_len+ROWS-2.
  - In cycle s, out_a[r] = buf[s-r][r] when 0 <= s-r < k_len, else 0.
  - out_fire=1 in every STREAM cycle.
  - After the last cycle, go to DRAIN.
- DRAIN:
  - out_fire=0 and out_a all 0 for DRAIN_CYC cycles.
  - On the last DRAIN cycle, done=1 for exactly one cycle; the next state is IDLE.
- busy=1 from the cycle after start is accepted through the done cycle inclusive.
- Latency: the first out_fire rises 1 cycle after the last accepted beat.
- Tile cycle count, from the start edge to the cycle after done: LOAD_beats + k_len + ROWS-1 + DRAIN_CYC + 1, with zero-stall upstream.
- Outside STREAM, out_a is held at 0. No X ever propagates to the array.
- start may be asserted in the cycle immediately after done; it is accepted because the state is IDLE.

Test Plan:
- Reset mid-STREAM:
  - k_len=3 tile; assert rstn during STREAM cycle s=2.
  - Next cycle: out_fire=0, out_a=0, busy=0, in_ready=0, no done.
  - A new start with k_len=2 then completes normally.
- Basic skew, k_len=2:
  - Vectors V0={0x01,0x02,0x03,0x04} and V1={0x11,0x12,0x13,0x14}, streamed with no stalls.
  - out_fire is high for 5 cycles, with out_a per cycle:
    - s0 {01,00,00,00}
    - s1 {11,02,00,00}
    - s2 {00,12,03,00}
    - s3 {00,00,13,04}
    - s4 {00,00,00,14}
  - Then 4 DRAIN cycles, with done on the 4th.
- Upstream stalls:
  - k_len=4; in_valid toggles 1,0,1,0,...
  - All 4 vectors are accepted in order; in_ready deasserts the cycle after the 4th accept.
  - STREAM output matches the no-stall case, with 7 fire cycles.
- Saturation:
  - k_len=20 with MAX_K=16.
  - Exactly 16 beats are accepted; out_fire is high for 19 cycles.
- Ignored start:
  - start with k_len=0 in IDLE -> busy stays 0, no done.
  - start pulsed during LOAD and during DRAIN -> no effect on the count or timing of the current tile.
- Back-to-back tiles:
  - Assert start in the cycle after done.
  - The second tile is accepted immediately; busy drops low for exactly the done+1 cycle only.
